// File: rtl/fetch_line_buffer_pkg.sv
// Shared types and constants for the fetch line buffer.
//   fetch_tag_t : request tag travelling alongside the memory read latency
//   line_t      : one buffered 128-bit line with its first valid word and line PC
package fetch_line_buffer_pkg;

    localparam int unsigned INSTR_PER_LINE = 4;
    localparam int unsigned LINE_BYTES     = 16;

    typedef struct packed {
        logic        valid;
        logic [1:0]  start_offset;
        logic [31:0] line_pc;
    } fetch_tag_t;

    typedef struct packed {
        logic [127:0] data;
        logic [1:0]   start_offset;
        logic [31:0]  line_pc;
    } line_t;

    function automatic logic [31:0] line_align(input logic [31:0] pc);
        return {pc[31:4], 4'b0000};
    endfunction

endpackage

// File: rtl/fetch_line_buffer_if.sv
// Bus bundle between the fetch line buffer, instruction memory and decode.
//   master : the fetch block (drives readAddress and the instruction handshake outputs)
//   slave  : the environment (memory + decode + backend redirect)
interface fetch_line_buffer_if;

    logic         redirect;
    logic [31:0]  redirectTarget;
    logic [31:0]  readAddress;
    logic [127:0] readData;
    logic         readValid;
    logic         instrValid;
    logic         instrReady;
    logic [31:0]  instruction;
    logic [31:0]  instrPc;

    modport master (
        input  redirect, redirectTarget, readData, readValid, instrReady,
        output readAddress, instrValid, instruction, instrPc
    );

    modport slave (
        output redirect, redirectTarget, readData, readValid, instrReady,
        input  readAddress, instrValid, instruction, instrPc
    );

endinterface

// File: rtl/fetch_line_buffer_fifo.sv
// Circular buffer of fetched lines.
//   clock, reset : clock and asynchronous active-high reset
//   flush_i      : empties the buffer (wins over push/pop)
//   push_i/line_i: write a line at the tail
//   pop_i        : drop the head line
//   head_o/next_o: combinational reads of the head entry and the one behind it
//   count_o      : occupancy 0..LINE_DEPTH
module fetch_line_fifo
    import fetch_line_buffer_pkg::*;
#(
    parameter int unsigned LINE_DEPTH = 4,
    localparam int unsigned PtrW = $clog2(LINE_DEPTH),
    localparam int unsigned CntW = $clog2(LINE_DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            push_i,
    input  line_t           line_i,
    input  logic            pop_i,
    output line_t           head_o,
    output line_t           next_o,
    output logic [CntW-1:0] count_o
);

    line_t            mem_q [LINE_DEPTH];
    logic [PtrW-1:0]  head_q, tail_q;
    logic [CntW-1:0]  count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally.
            if (push_i) tail_q <= tail_q + PtrW'(1);
            if (pop_i)  head_q <= head_q + PtrW'(1);
            count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clock) begin
        if (push_i && !flush_i) mem_q[tail_q] <= line_i;
    end

    assign head_o  = mem_q[head_q];
    assign next_o  = mem_q[head_q + PtrW'(1)];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_line_buffer.sv
// Fetch stage driving the instruction memory read port and feeding decode.
//   clock, reset : clock and asynchronous active-high reset
//   bus (master) : redirect/redirectTarget from the backend, readAddress/readData/
//                  readValid to memory, instrValid/instrReady/instruction/instrPc to decode
// Lines are requested while buffered + in-flight lines fit in LINE_DEPTH; a tag per
// request rides a MEM_LATENCY-deep shift register so returning data can be matched.
module fetch_line_buffer
    import fetch_line_buffer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned LINE_DEPTH  = 4,
    parameter int unsigned MEM_LATENCY = 2
) (
    input logic                 clock,
    input logic                 reset,
    fetch_line_buffer_if.master bus
);

    localparam int unsigned CntW = $clog2(LINE_DEPTH + 1);

    logic [31:0]     fetch_pc_q;
    logic            first_q;     // next issued line is the first after reset/redirect
    fetch_tag_t      tag_q [MEM_LATENCY];
    logic [1:0]      head_off_q, head_off_d;

    fetch_tag_t      tag_in, tag_end;
    line_t           head, next, cap_line;
    logic [CntW-1:0] occ, inflight;
    logic            issue, capture, hs, pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            inflight = inflight + CntW'(tag_q[i].valid);
        end
    end

    assign issue   = !bus.redirect &&
                     (({1'b0, occ} + {1'b0, inflight}) < (CntW + 1)'(LINE_DEPTH));
    assign tag_end = tag_q[MEM_LATENCY-1];
    assign capture = !bus.redirect && tag_end.valid && bus.readValid;

    always_comb begin
        tag_in = '0;
        if (issue) begin
            tag_in.valid        = 1'b1;
            tag_in.start_offset = first_q ? fetch_pc_q[3:2] : 2'd0;
            tag_in.line_pc      = line_align(fetch_pc_q);
        end
    end

    assign cap_line = '{data: bus.readData, start_offset: tag_end.start_offset,
                        line_pc: tag_end.line_pc};

    fetch_line_fifo #(
        .LINE_DEPTH (LINE_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (bus.redirect),
        .push_i  (capture),
        .line_i  (cap_line),
        .pop_i   (pop),
        .head_o  (head),
        .next_o  (next),
        .count_o (occ)
    );

    assign bus.readAddress = line_align(fetch_pc_q);
    assign bus.instrValid  = !bus.redirect && (occ != '0);
    assign bus.instruction = head.data[{head_off_q, 5'd0} +: 32];
    assign bus.instrPc     = {head.line_pc[31:4], head_off_q, 2'b00};

    assign hs  = bus.instrValid && bus.instrReady;
    assign pop = hs && (head_off_q == 2'd3);

    always_comb begin
        head_off_d = head_off_q;
        if (bus.redirect) begin
            head_off_d = bus.redirectTarget[3:2];
        end else if (hs) begin
            if (head_off_q != 2'd3)  head_off_d = head_off_q + 2'd1;
            else if (occ > CntW'(1)) head_off_d = next.start_offset;
            else if (capture)        head_off_d = tag_end.start_offset;
            else                     head_off_d = 2'd0;
        end else if ((occ == '0) && capture) begin
            // A line landing in an empty buffer sets where its words start.
            head_off_d = tag_end.start_offset;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            first_q    <= 1'b1;
            head_off_q <= RESET_PC[3:2];
            for (int i = 0; i < int'(MEM_LATENCY); i++) tag_q[i] <= '0;
        end else begin
            head_off_q <= head_off_d;
            if (bus.redirect) begin
                fetch_pc_q <= {bus.redirectTarget[31:2], 2'b00};
                first_q    <= 1'b1;
                for (int i = 0; i < int'(MEM_LATENCY); i++) tag_q[i] <= '0;
            end else begin
                if (issue) begin
                    fetch_pc_q <= fetch_pc_q + LINE_BYTES;
                    first_q    <= 1'b0;
                end
                tag_q[0] <= tag_in;
                for (int i = 1; i < int'(MEM_LATENCY); i++) tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // A valid tag without returned data means the memory broke its latency contract.
    always_ff @(posedge clock) begin
        if (!reset && !bus.redirect) assert (!(tag_end.valid && !bus.readValid));
    end

    logic unused_bits;
    assign unused_bits = ^{head.start_offset, head.line_pc[3:0], next.data, next.line_pc,
                           bus.redirectTarget[1:0]};

endmodule

// File: tb/tb_fetch_line_buffer.sv
module tb_fetch_line_buffer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_line_buffer_if ifa ();
    fetch_line_buffer_if ifb ();

    fetch_line_buffer #(
        .RESET_PC    (32'h0000_0000),
        .LINE_DEPTH  (4),
        .MEM_LATENCY (2)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    fetch_line_buffer #(
        .RESET_PC    (32'hFFFF_FFF8),
        .LINE_DEPTH  (4),
        .MEM_LATENCY (2)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    // Instruction memory model: contents are a fixed function of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        return {mem_word(a + 32'd12), mem_word(a + 32'd8), mem_word(a + 32'd4), mem_word(a)};
    endfunction

    logic [31:0] ma1, ma2, mb1, mb2;
    always @(posedge clock) begin
        ma1 <= ifa.readAddress;
        ma2 <= ma1;
        mb1 <= ifb.readAddress;
        mb2 <= mb1;
    end
    assign ifa.readData  = mem_line(ma2);
    assign ifa.readValid = 1'b1;
    assign ifb.readData  = mem_line(mb2);
    assign ifb.readValid = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    // Bounded wait for ifa.instrValid; n = negedges waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (!ifa.instrValid && n < 12) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] qb_pc [$];
    logic [31:0] qb_in [$];
    logic [31:0] exp_wrap [4];
    logic [31:0] exp_pc;
    int          n, gap, max_gap;
    logic        pre_valid;

    initial begin
        ifa.redirect = 1'b0;
        ifa.redirectTarget = '0;
        ifa.instrReady = 1'b1;
        ifb.redirect = 1'b0;
        ifb.redirectTarget = '0;
        ifb.instrReady = 1'b1;

        tbl[0] = '{32'h00, 1'b0, 32'h00};
        tbl[1] = '{32'h10, 1'b0, 32'h00};
        tbl[2] = '{32'h20, 1'b0, 32'h00};
        tbl[3] = '{32'h30, 1'b1, 32'h00};
        tbl[4] = '{32'h40, 1'b1, 32'h04};
        tbl[5] = '{32'h40, 1'b1, 32'h08};
        tbl[6] = '{32'h40, 1'b1, 32'h0C};
        tbl[7] = '{32'h40, 1'b1, 32'h10};
        tbl[8] = '{32'h50, 1'b1, 32'h14};
        tbl[9] = '{32'h50, 1'b1, 32'h18};
        exp_wrap[0] = 32'hFFFF_FFF8;
        exp_wrap[1] = 32'hFFFF_FFFC;
        exp_wrap[2] = 32'h0000_0000;
        exp_wrap[3] = 32'h0000_0004;

        // Table: cycle-by-cycle after reset, ready held; dut_b collects its wrap sequence.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            check($sformatf("tbl_addr_c%0d", c), ifa.readAddress, tbl[c].addr);
            check($sformatf("tbl_valid_c%0d", c), 32'(ifa.instrValid), 32'(tbl[c].valid));
            if (tbl[c].valid) begin
                check($sformatf("tbl_pc_c%0d", c), ifa.instrPc, tbl[c].pc);
                check($sformatf("tbl_instr_c%0d", c), ifa.instruction, mem_word(tbl[c].pc));
            end
            if (ifb.instrValid && qb_pc.size() < 4) begin
                qb_pc.push_back(ifb.instrPc);
                qb_in.push_back(ifb.instruction);
            end
        end
        check("wrap_count", 32'(qb_pc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_pc%0d", i),
                  (i < qb_pc.size()) ? qb_pc[i] : 32'hDEAD_DEAD, exp_wrap[i]);
            check($sformatf("wrap_instr%0d", i),
                  (i < qb_in.size()) ? qb_in[i] : 32'hDEAD_DEAD, mem_word(exp_wrap[i]));
        end

        // Back-pressure from reset: exactly four lines, then a burst of 16 with no bubbles.
        ifa.instrReady = 1'b0;
        do_reset();
        repeat (10) tick();
        check("bp_stall_addr", ifa.readAddress, 32'h40);
        check("bp_valid", 32'(ifa.instrValid), 32'd1);
        check("bp_head_pc", ifa.instrPc, 32'h0);
        ifa.instrReady = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("bp_burst_valid%0d", i), 32'(ifa.instrValid), 32'd1);
            check($sformatf("bp_burst_pc%0d", i), ifa.instrPc, 32'(i * 4));
            check($sformatf("bp_burst_instr%0d", i), ifa.instruction, mem_word(32'(i * 4)));
            tick();
        end
        check("bp_issue_resumed", 32'(ifa.readAddress > 32'h40), 32'd1);

        // Redirect with lines buffered and in flight, ready high in the same cycle.
        ifa.instrReady = 1'b0;
        do_reset();
        repeat (4) tick();
        check("rd_pre_valid", 32'(ifa.instrValid), 32'd1);
        ifa.redirect = 1'b1;
        ifa.redirectTarget = 32'h0000_010A;
        ifa.instrReady = 1'b1;
        #1;
        check("rd_cycle_valid", 32'(ifa.instrValid), 32'd0);
        @(negedge clock);
        ifa.redirect = 1'b0;
        #1;
        wait_valid(n);
        check("rd_latency", 32'(n), 32'd3);
        check("rd_pc0", ifa.instrPc, 32'h108);
        check("rd_instr0", ifa.instruction, mem_word(32'h108));
        tick();
        check("rd_pc1", ifa.instrPc, 32'h10C);
        tick();
        check("rd_pc2", ifa.instrPc, 32'h110);
        check("rd_instr2", ifa.instruction, mem_word(32'h110));

        // Asynchronous reset while an instruction is being offered.
        @(negedge clock);
        #2;
        pre_valid = ifa.instrValid;
        check("ar_pre_valid", 32'(pre_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("ar_valid_drop", 32'(ifa.instrValid), 32'd0);
        check("ar_addr", ifa.readAddress, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        wait_valid(n);
        check("ar_latency", 32'(n), 32'd3);
        check("ar_restart_pc", ifa.instrPc, 32'h0);

        // Random ready/redirect against a PC-sequence model.
        do_reset();
        exp_pc = 32'h0;
        gap = 0;
        max_gap = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            ifa.redirect = ($urandom_range(0, 19) == 0);
            ifa.redirectTarget = $urandom;
            ifa.instrReady = 1'($urandom_range(0, 1));
            #1;
            check("rnd_align", 32'(ifa.readAddress[3:0]), 32'd0);
            if (ifa.redirect) begin
                check("rnd_redir_valid", 32'(ifa.instrValid), 32'd0);
                exp_pc = {ifa.redirectTarget[31:2], 2'b00};
                gap = 0;
            end else if (ifa.instrValid) begin
                gap = 0;
                if (ifa.instrReady) begin
                    check("rnd_pc", ifa.instrPc, exp_pc);
                    check("rnd_instr", ifa.instruction, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                end
            end else begin
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
        end
        check("rnd_max_gap_ok", 32'(max_gap <= 3), 32'd1);

        ifa.redirect = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
